link_serializer: RTL and testbench
==================================

Name: link_serializer

Overview:
- Downstream output stage of a node: takes 32-bit instruction words plus a destination select and buffers them in a small FIFO.
- Serializes each word MSB-first onto one shared data line, with a generated serial clock and a per-destination frame select (self/left/right).
- Feeds the neighbouring nodes' receive ports, replacing parallel word transfer with framed serial transfer.

Parameters:
- DATA_W, 32, instruction word width in bits.
- FIFO_DEPTH, 4, word buffer entries; must be a power of 2, at least 2.
- CLK_DIV, 2, clk cycles per serial-clock half-period; at least 1.
- GAP_CYCLES, 2, idle cycles with all selects low between frames; at least 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_instr  input  DATA_W  instruction word to send.
- enable  input  2  destination: 00 none, 01 self, 10 left, 11 right.
- in_valid  input  1  in_instr/enable valid this cycle.
- in_ready  output  1  FIFO can accept a word; equals not-full.
- sclk  output  1  serial clock; receiver samples mosi on its rising edge.
- mosi  output  1  serial data.
- check_self  output  1  frame select to self port, active high.
- check_left  output  1  frame select to left neighbour, active high.
- check_right  output  1  frame select to right neighbour, active high.
- busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
- frame_done  output  1  one-cycle pulse when the last bit period of a frame completes.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE; sclk, mosi, all check_*, busy, frame_done = 0; in_ready = 1.
- Accept: a word is taken when in_valid && in_ready at a rising edge.
  - enable=00 words are accepted and discarded, never stored.
  - When full, in_ready=0 in that cycle even if a pop occurs in the same cycle; there is no bypass.
- FIFO: write and read pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when not full and not empty leaves the occupancy unchanged.
- FSM states IDLE, LOAD, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and its dest register, then go to LOAD.
  - LOAD (1 cycle): the selected check_* = 1, mosi = word[DATA_W-1], sclk = 0.
  - SHIFT: each bit lasts 2*CLK_DIV cycles; sclk = 0 for the first CLK_DIV cycles, then 1 for CLK_DIV cycles.
    - mosi changes only at a bit boundary, i.e. on sclk's falling transition.
    - The bit counter counts DATA_W bits.
    - After the last high half: frame_done pulses, the check is dropped, go to GAP.
  - GAP: all check_* = 0 and sclk = 0 for GAP_CYCLES cycles, then IDLE.
- Exactly one check_* is high during LOAD and SHIFT; none is high otherwise.
- Latency: word accepted at edge t, FIFO previously empty, FSM IDLE:
  - pop at edge t+1; check_* high from cycle t+2;
  - first sclk rise at t+2+1+CLK_DIV;
  - check high for 1+DATA_W*2*CLK_DIV cycles (129 at defaults).
- Back-to-back: the next frame's LOAD begins 1 cycle after GAP ends (the IDLE pop cycle). Frame period at defaults = 129+2+1 = 132 cycles.
- Reset mid-frame: outputs drop to 0 immediately and asynchronously. The partial frame and all buffered words are lost.
- Inputs changing while in_ready=0 have no effect.

Optional Feature:
- LINK_PARITY_EN defined:
  - One extra bit period follows the DATA_W data bits, carrying even parity (XOR of all data bits).
  - check stays high through it; frame length = 1+(DATA_W+1)*2*CLK_DIV.
  - frame_done pulses after the parity bit.
- LINK_PARITY_EN undefined: exactly DATA_W bits, no parity logic.

Decomposition:
- Package link_pkg:
  - destination encodings DEST_NONE/SELF/LEFT/RIGHT (2-bit);
  - FSM state enum;
  - default DATA_W and GAP_CYCLES constants.
- Sub-module link_fifo:
  - parameterized sync FIFO storing {enable, in_instr};
  - push/pop/full/empty;
  - async active-low reset.
- Shift FSM stays in link_serializer.

Test Plan:
- Single word 0xA5A5_0F0F, enable=10, idle → check_left high cycles t+2..t+130. The 32 bits sampled on sclk rises equal 0xA5A50F0F MSB-first; frame_done pulses once; check_self/right stay 0.
- Push 5 words, enable=01, in_valid held each cycle → 4 accepted, in_ready=0 on the 5th until the first pop. Frames appear in order, each separated by 2 GAP cycles plus the 1-cycle IDLE pop.
- Push 0xDEAD_BEEF with enable=00, then 0x1234_5678 with enable=11 → only one frame, on check_right, carrying 0x12345678.
- Assert rst_n=0 at bit 10 of a frame, with 2 words queued → all outputs 0 at once. After release, busy=0, in_ready=1, and no frame starts.
- CLK_DIV=1, alternating pattern 0x5555_5555 → sclk toggles every cycle; frame length 65 cycles with check high.
- With LINK_PARITY_EN defined, word 0x0000_0007 → 33rd bit = 1; frame length 1+33*2*CLK_DIV cycles.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and defaults for the serial link output stage.
// Destination codes, FSM state encoding and default widths.
package link_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_GAP_CYCLES = 2;

   localparam logic [1:0] DEST_NONE  = 2'b00;
   localparam logic [1:0] DEST_SELF  = 2'b01;
   localparam logic [1:0] DEST_LEFT  = 2'b10;
   localparam logic [1:0] DEST_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } linkState_t;

endpackage

// File: rtl/link_fifo.sv
// Small synchronous FIFO holding {dest, word} entries for the link.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module link_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;

   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) &&
                    (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign popData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push && !full) wrPtr <= wrPtr + PTR_ONE;
         if (pop && !empty) rdPtr <= rdPtr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/link_serializer.sv
// Buffers words and shifts them MSB-first onto a framed serial link.
// Define LINK_PARITY_EN to append an even-parity bit to each frame.
module link_serializer
   import link_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [1:0]        enable,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              sclk,
   output logic              mosi,
   output logic              check_self,
   output logic              check_left,
   output logic              check_right,
   output logic              busy,
   output logic              frame_done
);

`ifdef LINK_PARITY_EN
   localparam int NBITS = DATA_W + 1;
`else
   localparam int NBITS = DATA_W;
`endif
   localparam int SUB_W = $clog2(2 * CLK_DIV);
   localparam int BIT_W = $clog2(NBITS);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [SUB_W-1:0] SUB_HIGH = SUB_W'(CLK_DIV);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   linkState_t       state, stateNext;
   logic [NBITS-1:0] shReg, shNext, loadWord;
   logic [1:0]       dest, destNext;
   logic [SUB_W-1:0] subCnt, subNext;
   logic [BIT_W-1:0] bitCnt, bitNext;
   logic [GAP_W-1:0] gapCnt, gapNext;

   logic              fifoFull, fifoEmpty, pop, push, active;
   logic [DATA_W+1:0] headEntry;
   logic [DATA_W-1:0] headWord;
   logic [1:0]        headDest;

   assign in_ready = !fifoFull;
   // dest=NONE words are consumed from the port but never stored
   assign push     = in_valid && in_ready && (enable != DEST_NONE);
   assign headWord = headEntry[DATA_W-1:0];
   assign headDest = headEntry[DATA_W+1:DATA_W];

`ifdef LINK_PARITY_EN
   assign loadWord = {headWord, ^headWord};
`else
   assign loadWord = headWord;
`endif

   link_fifo #(
      .WIDTH(DATA_W + 2),
      .DEPTH(FIFO_DEPTH)
   ) uFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pushData({enable, in_instr}),
      .pop     (pop),
      .popData (headEntry),
      .full    (fifoFull),
      .empty   (fifoEmpty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         shReg  <= '0;
         dest   <= DEST_NONE;
         subCnt <= '0;
         bitCnt <= '0;
         gapCnt <= '0;
      end else begin
         state  <= stateNext;
         shReg  <= shNext;
         dest   <= destNext;
         subCnt <= subNext;
         bitCnt <= bitNext;
         gapCnt <= gapNext;
      end
   end

   always_comb begin
      stateNext  = state;
      shNext     = shReg;
      destNext   = dest;
      subNext    = subCnt;
      bitNext    = bitCnt;
      gapNext    = gapCnt;
      pop        = 1'b0;
      active     = 1'b0;
      sclk       = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               shNext    = loadWord;
               destNext  = headDest;
               subNext   = '0;
               bitNext   = '0;
               stateNext = LOAD;
            end
         end
         LOAD: begin
            active    = 1'b1;
            stateNext = SHIFT;
         end
         SHIFT: begin
            active  = 1'b1;
            sclk    = (subCnt >= SUB_HIGH);
            subNext = subCnt + SUB_W'(1);
            // bit boundary coincides with the sclk falling edge
            if (subCnt == SUB_LAST) begin
               subNext = '0;
               shNext  = shReg << 1;
               bitNext = bitCnt + BIT_W'(1);
               if (bitCnt == BIT_LAST) begin
                  frame_done = 1'b1;
                  gapNext    = '0;
                  stateNext  = GAP;
               end
            end
         end
         GAP: begin
            gapNext = gapCnt + GAP_W'(1);
            if (gapCnt == GAP_LAST) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign mosi        = active && shReg[NBITS-1];
   assign check_self  = active && (dest == DEST_SELF);
   assign check_left  = active && (dest == DEST_LEFT);
   assign check_right = active && (dest == DEST_RIGHT);
   assign busy        = (state != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_link_serializer.sv
// Directed bench for link_serializer: default divider instance (A)
// and a CLK_DIV=1 instance (B); frames recorded by a negedge monitor.
`timescale 1ns/1ps
module tb_link_serializer;
   import link_pkg::*;

`ifdef LINK_PARITY_EN
   localparam int NB = 33;
`else
   localparam int NB = 32;
`endif
   localparam int LEN_A    = 1 + NB * 2 * 2;
   localparam int LEN_B    = 1 + NB * 2 * 1;
   localparam int PERIOD_A = LEN_A + 2 + 1;

   typedef struct {
      logic [63:0] bits;
      int          nb;
      int          len;
      logic [2:0]  sel;
      int          fd;
      int          multi;
      longint      start;
      longint      rise;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic [1:0]  enable = '0;
   logic        validA = 1'b0;
   logic        validB = 1'b0;
   logic readyA, sclkA, mosiA, csA, clA, crA, busyA, fdA;
   logic readyB, sclkB, mosiB, csB, clB, crB, busyB, fdB;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   frame_t qA[$];
   frame_t qB[$];
   frame_t cur[2];
   bit     inFrame[2];
   bit     prevSc[2];
   int     stray[2];

   logic [31:0] words [5] = '{32'h11111111, 32'h80000001,
                              32'hCAFEBABE, 32'h00FF00FF,
                              32'h76543210};

   link_serializer uDutA (
      .clk(clk), .rst_n(rst_n), .in_instr(instr), .enable(enable),
      .in_valid(validA), .in_ready(readyA), .sclk(sclkA),
      .mosi(mosiA), .check_self(csA), .check_left(clA),
      .check_right(crA), .busy(busyA), .frame_done(fdA)
   );

   link_serializer #(.CLK_DIV(1)) uDutB (
      .clk(clk), .rst_n(rst_n), .in_instr(instr), .enable(enable),
      .in_valid(validB), .in_ready(readyB), .sclk(sclkB),
      .mosi(mosiB), .check_self(csB), .check_left(clB),
      .check_right(crB), .busy(busyB), .frame_done(fdB)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input longint obs,
                        input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic monStep(input int k, input logic [2:0] chk,
                          input logic sc, input logic mo,
                          input logic fd);
      if (!rst_n) begin
         inFrame[k] = 1'b0;
         prevSc[k]  = 1'b0;
         return;
      end
      if (chk != 3'b000) begin
         if (!inFrame[k]) begin
            inFrame[k]   = 1'b1;
            cur[k].bits  = '0;
            cur[k].nb    = 0;
            cur[k].len   = 0;
            cur[k].sel   = '0;
            cur[k].fd    = 0;
            cur[k].multi = 0;
            cur[k].start = cyc;
            cur[k].rise  = -1;
         end
         cur[k].len = cur[k].len + 1;
         cur[k].sel = cur[k].sel | chk;
         if ($countones(chk) != 1) cur[k].multi = cur[k].multi + 1;
         if (sc && !prevSc[k]) begin
            cur[k].bits = {cur[k].bits[62:0], mo};
            cur[k].nb   = cur[k].nb + 1;
            if (cur[k].rise < 0) cur[k].rise = cyc;
         end
         if (fd) cur[k].fd = cur[k].fd + 1;
      end else begin
         if (fd) stray[k]++;
         if (inFrame[k]) begin
            inFrame[k] = 1'b0;
            if (k == 0) qA.push_back(cur[k]);
            else qB.push_back(cur[k]);
         end
      end
      prevSc[k] = sc;
   endtask

   always @(negedge clk) begin
      monStep(0, {crA, clA, csA}, sclkA, mosiA, fdA);
      monStep(1, {crB, clB, csB}, sclkB, mosiB, fdB);
   end

   function automatic frame_t popF(input bit b);
      frame_t z;
      z = '{bits: '0, nb: 0, len: 0, sel: '0, fd: 0, multi: 0,
            start: 0, rise: 0};
      if (!b && qA.size() > 0) z = qA.pop_front();
      if (b && qB.size() > 0) z = qB.pop_front();
      return z;
   endfunction

   task automatic pushOne(input bit toB, input logic [31:0] w,
                          input logic [1:0] en, output longint acc);
      int n = 0;
      @(negedge clk);
      instr  = w;
      enable = en;
      if (toB) validB = 1'b1;
      else validA = 1'b1;
      while (!(toB ? readyB : readyA) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", longint'(n < 500), 1);
      acc = cyc + 1;
      @(negedge clk);
      validA = 1'b0;
      validB = 1'b0;
   endtask

   task automatic waitQ(input bit b, input int n, input int limit,
                        input string tag);
      int c = 0;
      while ((b ? qB.size() : qA.size()) < n && c < limit) begin
         @(negedge clk);
         c++;
      end
      check(tag, longint'(c < limit), 1);
   endtask

   initial begin
      longint      acc;
      longint      prevStart;
      frame_t      f;
      int          base;
      int          stall;
      int          c;
      logic [63:0] w;

      prevStart = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outs",
            longint'({sclkA, mosiA, csA, clA, crA, busyA, fdA}), 0);
      check("reset_ready", longint'(readyA), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single word to the left neighbour
      pushOne(0, 32'hA5A50F0F, DEST_LEFT, acc);
      waitQ(0, 1, 400, "t1_timeout");
      f = popF(0);
      w = f.bits >> (NB - 32);
      check("t1_data", longint'(w[31:0]), 32'hA5A50F0F);
      check("t1_nbits", f.nb, NB);
      check("t1_len", f.len, LEN_A);
      check("t1_sel", longint'(f.sel), 3'b010);
      check("t1_onehot", f.multi, 0);
      check("t1_done", f.fd, 1);
      check("t1_latency", f.start - acc, 1);
      check("t1_first_rise", f.rise - f.start, 3);
      repeat (10) @(negedge clk);

      // fill the FIFO while a frame is already on the wire
      pushOne(0, 32'h0BADF00D, DEST_SELF, acc);
      repeat (2) @(negedge clk);
      validA = 1'b1;
      enable = DEST_SELF;
      for (int i = 0; i < 5; i++) begin
         instr = words[i];
         stall = 0;
         while (!readyA && stall < 400) begin
            @(negedge clk);
            stall++;
         end
         if (i < 4) begin
            check("t2_no_stall", stall, 0);
         end else begin
            check("t2_stalled", longint'(stall > 100), 1);
            check("t2_ready_at_load", longint'({csA, sclkA}), 2'b10);
         end
         @(negedge clk);
      end
      validA = 1'b0;
      waitQ(0, 6, 6 * PERIOD_A + 200, "t2_timeout");
      for (int i = 0; i < 6; i++) begin
         f = popF(0);
         w = f.bits >> (NB - 32);
         check("t2_data", longint'(w[31:0]),
               (i == 0) ? 32'h0BADF00D : words[i-1]);
         check("t2_sel", longint'(f.sel), 3'b001);
         if (i > 0) check("t2_period", f.start - prevStart, PERIOD_A);
         prevStart = f.start;
      end
      repeat (10) @(negedge clk);

      // dest NONE is swallowed, the next word goes right
      pushOne(0, 32'hDEADBEEF, DEST_NONE, acc);
      check("t3_none_busy", longint'(busyA), 0);
      pushOne(0, 32'h12345678, DEST_RIGHT, acc);
      waitQ(0, 1, 400, "t3_timeout");
      repeat (300) @(negedge clk);
      check("t3_frames", qA.size(), 1);
      f = popF(0);
      w = f.bits >> (NB - 32);
      check("t3_data", longint'(w[31:0]), 32'h12345678);
      check("t3_sel", longint'(f.sel), 3'b100);
      repeat (10) @(negedge clk);

      // reset mid-frame with two words queued
      pushOne(0, 32'hFFFFFFFF, DEST_SELF, acc);
      pushOne(0, 32'hFFFFFFFF, DEST_SELF, acc);
      pushOne(0, 32'hFFFFFFFF, DEST_SELF, acc);
      c = 0;
      while (!(inFrame[0] && cur[0].nb == 10) && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("t4_reach_bit10", longint'(c < 400), 1);
      check("t4_mosi_before", longint'(mosiA), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_outs_drop",
            longint'({sclkA, mosiA, csA, clA, crA, busyA, fdA}), 0);
      check("t4_ready_in_reset", longint'(readyA), 1);
      base = qA.size();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("t4_no_frame", qA.size(), base);
      check("t4_busy", longint'(busyA), 0);
      check("t4_ready", longint'(readyA), 1);

      // CLK_DIV=1 instance
      pushOne(1, 32'h55555555, DEST_SELF, acc);
      waitQ(1, 1, 300, "t5_timeout");
      f = popF(1);
      w = f.bits >> (NB - 32);
      check("t5_data", longint'(w[31:0]), 32'h55555555);
      check("t5_nbits", f.nb, NB);
      check("t5_len", f.len, LEN_B);
      check("t5_first_rise", f.rise - f.start, 2);
      check("t5_done", f.fd, 1);

`ifdef LINK_PARITY_EN
      repeat (10) @(negedge clk);
      pushOne(0, 32'h00000007, DEST_SELF, acc);
      waitQ(0, 1, 400, "t6_timeout");
      f = popF(0);
      check("t6_parity", longint'(f.bits[0]), 1);
      check("t6_word", longint'(f.bits[32:1]), 32'h00000007);
      check("t6_len", f.len, 1 + 33 * 2 * 2);
`endif

      repeat (5) @(negedge clk);
      check("stray_done", stray[0] + stray[1], 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
